// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential multiply/divide controller:
// FSM state encoding, default iteration counts and counter sizing.
package multdiv_pkg;

  localparam int DEF_MULT_CYCLES = 16;
  localparam int DEF_DIV_CYCLES  = 32;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_MULT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DIV  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

  // Width that can hold the largest terminal count without wrapping.
  function automatic int count_width(input int mult_cycles, input int div_cycles);
    int max_cycles;
    max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/multdiv_seq_cycle_counter.sv
// Iteration counter for multdiv_seq: synchronous clear has priority over
// enable; asynchronous active-low reset.
module cycle_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values, regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/multdiv_seq.sv
// Sequential multiply/divide controller: latches operands, strobes the external
// multiplier or divider, counts its iterations and registers the result.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  output logic        mult_start,
  input  logic [31:0] mult_result,
  input  logic        mult_ovf,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic [31:0] div_result,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam int               CNT_W     = count_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic [CNT_W-1:0]   count;
  logic               req;
  logic               div_by_zero;
  logic               mult_last;
  logic               div_last;
  logic               mult_done;
  logic               div_done;
  logic               cnt_clear;
  logic               cnt_enable;

  // Multiply wins when both requests arrive together.
  assign req         = ctrl_MULT | ctrl_DIV;
  assign div_by_zero = !ctrl_MULT && ctrl_DIV && (data_operandB == '0);

  assign mult_last = (state == ST_MULT) && (count == MULT_LAST);
  assign div_last  = (state == ST_DIV)  && (count == DIV_LAST);

  // A new request in the final iteration aborts that operation: no capture.
  assign mult_done = mult_last && !req;
  assign div_done  = div_last  && !req;

  assign cnt_enable = (state == ST_MULT) || (state == ST_DIV);
  assign cnt_clear  = req || mult_last || div_last;

  cycle_counter #(
    .WIDTH(CNT_W)
  ) u_cycle_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .count  (count)
  );

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      ST_MULT: if (mult_last) state_nxt = ST_DONE;
      ST_DIV:  if (div_last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = state;
    endcase
    // Requests are accepted in every state, including DONE and mid-operation.
    if (ctrl_MULT) begin
      state_nxt = ST_MULT;
    end else if (ctrl_DIV) begin
      state_nxt = div_by_zero ? ST_DONE : ST_DIV;
    end
  end

  // NOTE: every control and datapath register here has a reset value; these
  // are individual flops, not a memory array, so resetting them is cheap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      state <= state_nxt;
      if (req) begin
        op_a <= data_operandA;
        op_b <= data_operandB;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (div_by_zero) begin
      data_result    <= '0;
      data_exception <= 1'b1;
    end else if (mult_done) begin
      data_result    <= mult_result;
      data_exception <= mult_ovf;
    end else if (div_done) begin
      data_result    <= div_result;
      data_exception <= 1'b0;
    end
  end

  // Both units see the same held operands; they re-register them every cycle.
  assign mult_a = op_a;
  assign mult_b = op_b;
  assign div_a  = op_a;
  assign div_b  = op_b;

  assign mult_start     = (state == ST_MULT) && (count == '0);
  assign div_start      = (state == ST_DIV)  && (count == '0);
  assign data_resultRDY = (state == ST_DONE);
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq with behavioural multiplier/divider units,
// directed scenarios and randomized request streams.
module tb_multdiv_seq;

  localparam int MC = 16;
  localparam int DC = 32;

  typedef struct {
    int          req;
    int          due;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic        exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] mult_a, mult_b, div_a, div_b;
  logic [31:0] mult_result, div_result, data_result;
  logic        mult_start, div_start, mult_ovf;
  logic        data_exception, data_resultRDY, busy;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  op_t         cur_op, prev_op;
  int          mstart_cyc, dstart_cyc;
  logic [31:0] held_res;
  logic        held_exc;

  multdiv_seq #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .mult_a        (mult_a),
    .mult_b        (mult_b),
    .mult_start    (mult_start),
    .mult_result   (mult_result),
    .mult_ovf      (mult_ovf),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_start     (div_start),
    .div_result    (div_result),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint smul(input logic [31:0] a, input logic [31:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    longint q;
    if (b == '0) return '0;
    q = longint'($signed(a)) / longint'($signed(b));
    return q[31:0];
  endfunction

  // Behavioural external units: signed 32x32 multiply with overflow flag,
  // signed truncating divide.
  longint mprod;
  always_comb begin
    mprod       = smul(mult_a, mult_b);
    mult_result = mprod[31:0];
    mult_ovf    = (mprod > 64'sd2147483647) || (mprod < -64'sd2147483648);
  end
  assign div_result = sdiv(div_a, div_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic reset_model();
    sb.delete();
    cur_op     = '{req: -100, due: -100, a: '0, b: '0};
    prev_op    = cur_op;
    mstart_cyc = -100;
    dstart_cyc = -100;
    held_res   = '0;
    held_exc   = 1'b0;
  endtask

  function automatic logic in_op(input op_t op, input int c);
    return (c > op.req) && (c <= op.due);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a request in the current cycle; the expected completion goes on the scoreboard.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    op_t    op;
    int     c;
    longint p;
    c = cyc;
    if (sb.size() > 0 && sb[$].due > c) void'(sb.pop_back());
    prev_op = cur_op;
    if (prev_op.due > c) prev_op.due = c;
    op = '{req: c, due: 0, a: a, b: b};
    if (m) begin
      p          = smul(a, b);
      e.res      = p[31:0];
      e.exc      = (p != longint'($signed(e.res)));
      op.due     = c + MC + 2;
      mstart_cyc = c + 1;
    end else if (b == '0) begin
      e.res  = '0;
      e.exc  = 1'b1;
      op.due = c + 1;
    end else begin
      e.res      = sdiv(a, b);
      e.exc      = 1'b0;
      op.due     = c + DC + 2;
      dstart_cyc = c + 1;
    end
    e.due = op.due;
    sb.push_back(e);
    cur_op = op;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clk);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 20)) - 32'd10;
      1:       return $urandom & 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares every observable output against the scoreboard each cycle.
  always @(negedge clk) begin : monitor
    logic        exp_rdy;
    logic [31:0] ea, eb;
    exp_t        e;
    exp_rdy = (sb.size() > 0) && (sb[0].due == cyc);
    check("data_resultRDY", data_resultRDY, exp_rdy);
    if (exp_rdy) begin
      e        = sb.pop_front();
      held_res = e.res;
      held_exc = e.exc;
    end
    check("data_result", data_result, held_res);
    check("data_exception", data_exception, held_exc);
    check("busy", busy, in_op(cur_op, cyc) || in_op(prev_op, cyc));
    check("mult_start", mult_start, cyc == mstart_cyc);
    check("div_start", div_start, cyc == dstart_cyc);
    ea = (cyc > cur_op.req) ? cur_op.a : prev_op.a;
    eb = (cyc > cur_op.req) ? cur_op.b : prev_op.b;
    check("mult_a", mult_a, ea);
    check("mult_b", mult_b, eb);
    check("div_a", div_a, ea);
    check("div_b", div_b, eb);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, lat, g;
    logic        m, d;
    logic [31:0] a, b;

    reset_model();
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(2);

    // 7 * -3
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_cycles(MC + 3);
    // Overflowing multiply
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_cycles(MC + 3);
    // Divide by zero completes the next cycle
    issue(1'b0, 1'b1, 32'd100, 32'd0);
    wait_cycles(3);
    // Multiply aborted by a divide five cycles later
    issue(1'b1, 1'b0, 32'd2, 32'd3);
    wait_cycles(4);
    issue(1'b0, 1'b1, 32'd9, 32'd3);
    wait_cycles(DC + 4);
    // Simultaneous requests: multiply wins
    issue(1'b1, 1'b1, 32'd4, 32'd5);
    wait_cycles(MC + 3);
    // New request in the DONE cycle
    issue(1'b1, 1'b0, 32'd5, 32'd6);
    wait_cycles(MC + 1);
    issue(1'b0, 1'b1, 32'd50, 32'd7);
    wait_cycles(DC + 4);

    // Asynchronous reset in cycle 10 of a multiply
    issue(1'b1, 1'b0, 32'd11, 32'd13);
    wait_cycles(9);
    reset_n = 1'b0;
    reset_model();
    #1;
    check("busy_async_reset", busy, 1'b0);
    check("mult_start_async_reset", mult_start, 1'b0);
    check("data_result_async_reset", data_result, 32'd0);
    check("data_exception_async_reset", data_exception, 1'b0);
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(MC + 3);

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      a = rnd_operand();
      b = rnd_operand();
      if (k == 9) b = '0;
      m = (k <= 3) || (k == 8);
      d = (k >= 4);
      issue(m, d, a, b);
      lat = m ? (MC + 2) : ((b == '0) ? 1 : (DC + 2));
      case ($urandom_range(0, 2))
        0:       g = lat;
        1:       g = $urandom_range(1, lat);
        default: g = lat + $urandom_range(1, 3);
      endcase
      wait_cycles(g - 1);
    end

    wait_cycles(DC + 5);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 Parameter MULT_CYCLES, default 16, is the number of multiplier iterations after start (radix-4, 32-bit).
REQ-002 Parameter DIV_CYCLES, default 32, is the number of divider iterations after start.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port ctrl_MULT  input  1  is a one-cycle request to start a multiply.
REQ-006 Port ctrl_DIV  input  1  is a one-cycle request to start a divide.
REQ-007 Port data_operandA / data_operandB  input  32 each  are the operands, sampled only in a request cycle.
REQ-008 Port mult_a / mult_b  output  32 each  are the held multiplier and multiplicand driven to the multiplier unit.
REQ-009 Port mult_start  output  1  is the multiplier load/start strobe.
REQ-010 Port mult_result  input  32, and mult_ovf  input  1, carry the multiplier unit's product and overflow.
REQ-011 Port div_a / div_b  output  32 each, and div_start  output  1, drive the divider unit in the same way.
REQ-012 Port div_result  input  32 is the divider quotient.
REQ-013 Port data_result  output  32 is the registered result of the last completed operation.
REQ-014 Port data_exception  output  1 flags multiply overflow or divide-by-zero, valid with data_resultRDY.
REQ-015 Port data_resultRDY  output  1 pulses for exactly one cycle per completed operation.
REQ-016 Port busy  output  1 is high in any state except IDLE.

Function
REQ-017 The FSM states SHALL be IDLE, MULT, DIV and DONE.
- REQ-018 A request cycle SHALL latch both operands into internal registers.
- ctrl_MULT moves the FSM to MULT; ctrl_DIV moves it to DIV; the count is cleared.
REQ-019 If ctrl_MULT and ctrl_DIV are both high in one cycle, the multiply SHALL win and ctrl_DIV is ignored.
REQ-020 mult_start SHALL be high only in the first MULT cycle (count==0); div_start likewise in the first DIV cycle.
REQ-021 mult_a/mult_b and div_a/div_b SHALL hold the latched operands stable for the whole operation, since the units re-register operands every cycle.
- REQ-022 The count SHALL increment once per cycle in MULT/DIV.
- In MULT, at count==MULT_CYCLES, mult_result is captured into data_result, mult_ovf into data_exception, and the FSM goes to DONE.
- DIV does the same at count==DIV_CYCLES, with data_exception=0.
REQ-023 A request with data_operandB==0 via ctrl_DIV SHALL skip DIV and go straight to DONE with data_result=0 and data_exception=1; div_start stays low.
REQ-024 In DONE, data_resultRDY SHALL be high for one cycle, then the FSM returns to IDLE.
REQ-025 Latency SHALL be as follows (request in cycle 0):
- Multiply: data_resultRDY high in cycle MULT_CYCLES+2 (18 by default).
- Divide: data_resultRDY high in cycle DIV_CYCLES+2 (34 by default).
- Divide-by-zero: data_resultRDY high in cycle 1.
REQ-026 A new request arriving in MULT or DIV SHALL abort the current operation and restart with new operands; no data_resultRDY is produced for the aborted operation.
REQ-027 A request in the DONE cycle SHALL be accepted (next state MULT/DIV) while data_resultRDY still pulses for the finished operation.
REQ-028 data_result and data_exception SHALL hold their value until the next capture.
REQ-029 The count SHALL be wide enough for max(MULT_CYCLES, DIV_CYCLES) and SHALL never wrap within an operation.

Reset
REQ-030 Asserting reset_n low SHALL immediately (asynchronously) force the following:
- FSM to IDLE, count to 0, operand registers to 0.
- data_result to 0, data_exception to 0.
- data_resultRDY, mult_start, div_start and busy to 0.
REQ-031 Reset mid-operation SHALL discard the operation with no data_resultRDY pulse; operation resumes on the first edge after reset_n rises.

Structure
REQ-032 The FSM state encoding and default cycle counts SHALL reside in shared package multdiv_pkg.
REQ-033 One sub-module, cycle_counter (clear, enable, count output, async active-low reset), is natural; everything else is flat.
REQ-034 The multiplier and divider units SHALL be instantiated outside this block.

Verification
REQ-035 ctrl_MULT with A=7, B=-3, using a bench model of the multiplier unit:
- mult_start high in cycle 1 only.
- data_resultRDY high in cycle 18 with data_result=-21, data_exception=0.
REQ-036 ctrl_MULT with A=32'h0001_0000, B=32'h0001_0000 -> cycle 18: data_exception=1 (overflow).
REQ-037 ctrl_DIV with A=100, B=0 -> cycle 1: data_resultRDY=1, data_result=0, data_exception=1; div_start never high.
REQ-038 ctrl_MULT (A=2, B=3) followed by ctrl_DIV (A=9, B=3) in cycle 5:
- No data_resultRDY for the multiply.
- data_resultRDY in cycle 39 with data_result=3.
REQ-039 ctrl_MULT and ctrl_DIV both high with A=4, B=5 -> only mult_start fires; data_result=20 in cycle 18.
REQ-040 reset_n low in cycle 10 of a multiply:
- busy and mult_start are 0 immediately.
- No data_resultRDY follows.
- data_result reads 0.
